// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit ALU and its command sequencer.
//   ALU_WIDTH    default datapath width
//   OP_*         ALU control codes (control[0] doubles as the carry-in)
//   seq_state_t  sequencer states
//   sat_inc8     saturating 8-bit increment used by the statistics counters
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } seq_state_t;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_accum_seq.sv
// alu_accum_seq: command sequencer and accumulator wrapped around the external
// 4-bit ALU. One command at a time is accepted on the cmd_* handshake; a load
// writes the accumulator directly, an operation applies cmd_op with operand
// cmd_data to the accumulator cmd_count+1 times through the ALU. The final
// accumulator value and zero flag are returned on the rsp_* handshake.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_load, cmd_op, cmd_data, cmd_count   command fields
//   alu_a, alu_b, alu_control   registered ALU operands / control
//   alu_result, alu_zero        combinational ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero        accumulator value and zero flag
//   op_cnt, zero_cnt            (only with ALU_ACCUM_SEQ_STAT_EN) saturating
//                               counts of responses and of zero responses
//
// Build option: define ALU_ACCUM_SEQ_STAT_EN to add the statistics counters.
module alu_accum_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
`ifdef ALU_ACCUM_SEQ_STAT_EN
  ,
  output logic [7:0]       op_cnt,
  output logic [7:0]       zero_cnt
`endif
);

  seq_state_t       state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic             zflag_r, zflag_s;
  logic [2:0]       op_r, op_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [CNT_W-1:0] iter_r, iter_s;

  // Next-state and next-register logic for the sequencer.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    zflag_s = zflag_r;
    op_s    = op_r;
    b_s     = b_r;
    iter_s  = iter_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            acc_s   = cmd_data;
            zflag_s = (cmd_data == {WIDTH{1'b0}});
            state_s = RESP;
          end else begin
            op_s    = cmd_op;
            b_s     = cmd_data;
            iter_s  = cmd_count;
            state_s = EXEC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        // Every EXEC edge commits one ALU pass; iter counts the passes left.
        acc_s   = alu_result;
        zflag_s = alu_zero;
        if (iter_r == {CNT_W{1'b0}}) begin
          state_s = RESP;
        end else begin
          iter_s  = iter_r - CNT_W'(1);
          state_s = EXEC;
        end
      end
      RESP: begin
        // Response is held (all registers frozen) until the consumer takes it.
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {WIDTH{1'b0}};
      zflag_r <= 1'b1;
      op_r    <= OP_AND;
      b_r     <= {WIDTH{1'b0}};
      iter_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      zflag_r <= zflag_s;
      op_r    <= op_s;
      b_r     <= b_s;
      iter_r  <= iter_s;
    end
  end

  // rst_n gates ready so no command can be taken while reset is asserted.
  assign cmd_ready   = (state_r == IDLE) && rst_n;
  assign rsp_valid   = (state_r == RESP);
  assign rsp_result  = acc_r;
  assign rsp_zero    = zflag_r;
  assign alu_a       = acc_r;
  assign alu_b       = b_r;
  assign alu_control = op_r;

`ifdef ALU_ACCUM_SEQ_STAT_EN
  logic [7:0] op_cnt_r;
  logic [7:0] zero_cnt_r;

  // Saturating response statistics, stepped on each response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_r   <= 8'd0;
      zero_cnt_r <= 8'd0;
    end else if ((state_r == RESP) && rsp_ready) begin
      op_cnt_r <= sat_inc8(op_cnt_r);
      if (zflag_r) begin
        zero_cnt_r <= sat_inc8(zero_cnt_r);
      end else begin
        zero_cnt_r <= zero_cnt_r;
      end
    end else begin
      op_cnt_r   <= op_cnt_r;
      zero_cnt_r <= zero_cnt_r;
    end
  end

  assign op_cnt   = op_cnt_r;
  assign zero_cnt = zero_cnt_r;
`endif

endmodule

// File: tb/tb_alu_accum_seq.sv
// tb_alu_accum_seq: directed bench for alu_accum_seq with a behavioural ALU
// as the datapath, a transaction-level reference model, a per-cycle compare
// process and hand-computed expectations for each directed command.
module tb_alu_accum_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_data = 4'h0;
  logic [1:0] cmd_count = 2'b00;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_control;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic       rsp_zero;
`ifdef ALU_ACCUM_SEQ_STAT_EN
  logic [7:0] op_cnt, zero_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_accum_seq #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ACCUM_SEQ_STAT_EN
    , .op_cnt(op_cnt), .zero_cnt(zero_cnt)
`endif
  );

  // Reference ALU datapath: bitwise and two's-complement arithmetic.
  always_comb begin
    case (alu_control)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a + ~alu_b + 4'd1;
      default: alu_result = 4'h0;
    endcase
  end
  assign alu_zero = (alu_result == 4'h0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic: apply op with operand b to a, reps times.
  function automatic int ref_fold(input int a, input int b, input int op, input int reps);
    int r = a;
    for (int i = 0; i < reps; i++) begin
      case (op)
        0: r = r & b;
        1: r = r | b;
        2: r = (r + b) % 16;
        3: r = (r - b + 16) % 16;
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  // Transaction-level model: phase 0 idle, 1 computing, 2 response pending.
  int m_phase, m_acc, m_zero, m_b, m_op, m_wait, m_ops, m_zeros;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_acc = 0; m_zero = 1; m_b = 0; m_op = 0;
      m_wait = 0; m_ops = 0; m_zeros = 0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          if (cmd_load) begin
            m_acc = int'(cmd_data); m_zero = (cmd_data == 4'h0); m_phase = 2;
          end else begin
            m_b = int'(cmd_data); m_op = int'(cmd_op);
            m_acc = ref_fold(m_acc, m_b, m_op, int'(cmd_count) + 1);
            m_zero = (m_acc == 0);
            m_wait = int'(cmd_count) + 1;
            m_phase = 1;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_phase = 2;
        end
        2: if (rsp_ready) begin
          m_phase = 0; m_ops++;
          if (m_zero != 0) m_zeros++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_cmd_ready", cmd_ready, (m_phase == 0) && rst_n);
    check("cmp_rsp_valid", rsp_valid, m_phase == 2);
    check("cmp_alu_b", alu_b, m_b);
    check("cmp_alu_control", alu_control, m_op);
    if (m_phase != 1) begin
      check("cmp_alu_a", alu_a, m_acc);
      check("cmp_rsp_result", rsp_result, m_acc);
      check("cmp_rsp_zero", rsp_zero, m_zero);
    end
`ifdef ALU_ACCUM_SEQ_STAT_EN
    check("cmp_op_cnt", op_cnt, (m_ops > 255) ? 255 : m_ops);
    check("cmp_zero_cnt", zero_cnt, (m_zeros > 255) ? 255 : m_zeros);
`endif
  end

  // Issue one command and collect its response with a hand-computed result.
  task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [3:0] d,
                        input logic [1:0] n, input logic [3:0] er, input logic ez,
                        input int elat, input int stall, input string nm);
    int k = 0;
    int lat = 1;
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_data = d; cmd_count = n;
    while (!cmd_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!cmd_ready) begin
      check({nm, "_accept_timeout"}, cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      // Stray command while busy; must be ignored.
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'h7;
      @(posedge clk); #1; lat++;
    end
    cmd_valid = 1'b0; cmd_load = 1'b0;
    check({nm, "_rsp_valid"}, rsp_valid, 1);
    check({nm, "_latency"}, lat, elat);
    check({nm, "_result"}, rsp_result, er);
    check({nm, "_zero"}, rsp_zero, ez);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({nm, "_stall_valid"}, rsp_valid, 1);
      check({nm, "_stall_result"}, rsp_result, er);
      check({nm, "_stall_zero"}, rsp_zero, ez);
      check({nm, "_stall_cmd_ready"}, cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({nm, "_after_valid"}, rsp_valid, 0);
    check({nm, "_after_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_zero", rsp_zero, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_control", alu_control, OP_AND);
    rst_n = 1'b1;
    #1;
    check("rst_release_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    do_cmd(1'b1, OP_AND, 4'h5, 2'd0, 4'h5, 1'b0, 1, 0, "load5");
    do_cmd(1'b0, OP_ADD, 4'h3, 2'd0, 4'h8, 1'b0, 2, 0, "add3");
    do_cmd(1'b1, OP_AND, 4'h5, 2'd0, 4'h5, 1'b0, 1, 0, "reload5");
    do_cmd(1'b0, OP_ADD, 4'h4, 2'd3, 4'h5, 1'b0, 5, 0, "add4x4");
    do_cmd(1'b1, OP_AND, 4'h3, 2'd0, 4'h3, 1'b0, 1, 0, "load3");
    do_cmd(1'b0, OP_SUB, 4'h3, 2'd0, 4'h0, 1'b1, 2, 5, "sub3_stall");
    do_cmd(1'b1, OP_AND, 4'hF, 2'd0, 4'hF, 1'b0, 1, 0, "loadF");
    do_cmd(1'b0, OP_ADD, 4'h1, 2'd0, 4'h0, 1'b1, 2, 0, "add_wrap");
    do_cmd(1'b0, OP_OR,  4'hA, 2'd1, 4'hA, 1'b0, 3, 0, "or_a");
    do_cmd(1'b0, OP_AND, 4'h3, 2'd0, 4'h2, 1'b0, 2, 0, "and_3");
    do_cmd(1'b0, OP_SUB, 4'h3, 2'd2, 4'h9, 1'b0, 4, 0, "sub3x3");
    do_cmd(1'b1, OP_AND, 4'h0, 2'd0, 4'h0, 1'b1, 1, 0, "load0");

    // Reset in the middle of a 4-pass operation.
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_data = 4'h2; cmd_count = 2'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_alu_a", alu_a, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_rsp_zero", rsp_zero, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort_release_cmd_ready", cmd_ready, 1);
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_rsp", rsp_valid, 0);
    end

    // Three responses after reset, exactly one of them zero.
    do_cmd(1'b1, OP_AND, 4'h6, 2'd0, 4'h6, 1'b0, 1, 0, "stat_load6");
    do_cmd(1'b0, OP_SUB, 4'h6, 2'd0, 4'h0, 1'b1, 2, 0, "stat_sub6");
    do_cmd(1'b0, OP_OR,  4'h9, 2'd0, 4'h9, 1'b0, 2, 0, "stat_or9");
`ifdef ALU_ACCUM_SEQ_STAT_EN
    check("stat_op_cnt", op_cnt, 3);
    check("stat_zero_cnt", zero_cnt, 1);
`endif
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
